// File: rtl/obuf.sv
// Output buffer for one switch port: a circular FIFO that queues packets for the downstream link,
// accepts a packet into a full FIFO only when the head leaves in the same cycle, and counts overflow drops.
module obuf #(
    parameter int PKTW  = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PKTW:0]            i,
    output logic [PKTW:0]            o,
    input  logic                     ordy,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic [7:0]               drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [PKTW-1:0] mem_q [DEPTH];

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      drop_q, drop_d;

    logic            in_vld;
    logic            not_empty;
    logic            is_full;
    logic            pop;
    logic            push;
    logic            ovf;

    assign in_vld    = i[PKTW];
    assign not_empty = (cnt_q != '0);
    assign is_full   = (cnt_q == CNT_FULL);

    // A full FIFO still accepts when the head drains in the same cycle.
    assign pop  = not_empty && ordy;
    assign push = in_vld && (!is_full || pop);
    assign ovf  = in_vld && !push;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        drop_d   = drop_q;
        // DEPTH is a power of two, so pointer wrap is natural AW-bit overflow.
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (ovf && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= i[PKTW-1:0];
    end

    always_comb begin
        o = '0;
        if (not_empty) o = {1'b1, mem_q[rd_ptr_q]};
    end

    assign full = is_full;
    assign cnt  = cnt_q;
    assign drop = drop_q;

endmodule

// File: tb/tb_obuf.sv
// Self-checking bench for obuf: directed scenarios plus random traffic against a queue-based model.
module tb_obuf;

    localparam int PKTW  = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [PKTW:0]   i;
    logic [PKTW:0]   o;
    logic            ordy;
    logic            full;
    logic [CW-1:0]   cnt;
    logic [7:0]      drop;

    int checks   = 0;
    int failures = 0;

    logic [PKTW-1:0] mq [$];
    int              mdrop = 0;

    obuf #(.PKTW(PKTW), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .i    (i),
        .o    (o),
        .ordy (ordy),
        .full (full),
        .cnt  (cnt),
        .drop (drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against what the model says the FIFO holds right now.
    task automatic check_model(input string tag);
        logic [PKTW:0] eo;
        eo = '0;
        if (mq.size() != 0) eo = {1'b1, mq[0]};
        chk({tag, ".o"},    32'(o),    32'(eo));
        chk({tag, ".cnt"},  32'(cnt),  32'(mq.size()));
        chk({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
        chk({tag, ".drop"}, 32'(drop), 32'(mdrop));
    endtask

    // One cycle: drive inputs after the falling edge, check the pre-edge state, then advance the model.
    task automatic step(input string tag, input logic v, input logic [PKTW-1:0] p, input logic r);
        bit do_pop, do_push;
        @(negedge clk);
        i    = {v, p};
        ordy = r;
        #1;
        check_model(tag);
        do_pop  = (mq.size() != 0) && r;
        do_push = v && ((mq.size() < DEPTH) || do_pop);
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(p);
        else if (v && mdrop < 255) mdrop++;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < DEPTH + 1; k++) step(tag, 1'b0, 8'($urandom), 1'b1);
    endtask

    initial begin
        rst  = 1'b0;
        i    = '0;
        ordy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.o",    32'(o),    32'h0);
        chk("reset.cnt",  32'(cnt),  32'h0);
        chk("reset.full", 32'(full), 32'h0);
        chk("reset.drop", 32'(drop), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Single packet latency: invisible in push cycle, visible next, gone after.
        step("single", 1'b1, 8'hA5, 1'b1);
        step("single", 1'b0, 8'h3C, 1'b1);
        chk("single.head", 32'(o), 32'h1A5);
        step("single", 1'b0, 8'h00, 1'b1);

        // Overflow: fifth packet into a stalled FIFO is dropped.
        for (int k = 1; k <= 5; k++) step("ovf_fill", 1'b1, 8'(k), 1'b0);
        step("ovf_hold", 1'b0, 8'hFF, 1'b0);
        chk("ovf.drop1", 32'(drop), 32'h1);
        chk("ovf.full1", 32'(full), 32'h1);
        drain("ovf_drain");

        // Full with simultaneous pop accepts the new packet.
        for (int k = 0; k < DEPTH; k++) step("fullpop_fill", 1'b1, 8'h60 + 8'(k), 1'b0);
        step("fullpop_push", 1'b1, 8'h77, 1'b1);
        chk("fullpop.cnt", 32'(cnt), 32'(DEPTH));
        drain("fullpop_drain");

        // Back-to-back stream through two pointer wraps.
        for (int k = 0; k < 10; k++) step("stream", 1'b1, 8'h10 + 8'(k), 1'b1);
        chk("stream.cnt", 32'(cnt), 32'h1);
        drain("stream_drain");

        // Drop counter saturation.
        for (int k = 0; k < 300; k++) step("sat", 1'b1, 8'($urandom), 1'b0);
        step("sat_hold", 1'b0, 8'h00, 1'b0);
        chk("sat.drop", 32'(drop), 32'hFF);
        drain("sat_drain");

        // Asynchronous reset with packets stored, released between edges.
        for (int k = 0; k < 3; k++) step("rst_fill", 1'b1, 8'hC0 + 8'(k), 1'b0);
        @(negedge clk);
        i = '0;
        #2 rst = 1'b0;
        #1;
        chk("async.o",    32'(o),    32'h0);
        chk("async.cnt",  32'(cnt),  32'h0);
        chk("async.drop", 32'(drop), 32'h0);
        chk("async.full", 32'(full), 32'h0);
        #1 rst = 1'b1;
        mq.delete();
        mdrop = 0;
        step("post_rst", 1'b1, 8'h5A, 1'b0);
        step("post_rst", 1'b0, 8'h00, 1'b1);
        chk("post_rst.head", 32'(o), 32'h15A);
        drain("post_rst_drain");

        // Random traffic with bursty ready.
        for (int k = 0; k < 500; k++)
            step("rand", 1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 45));
        drain("rand_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/obuf.md
OBUF -- requirements
Module: obuf

Interface
REQ-001 Parameter PKTW, default 8: packet MSB index; a packet is PKTW+1 bits; bit PKTW is the valid flag and bits PKTW-1:0 are the payload.
REQ-002 Parameter DEPTH, default 4: FIFO entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 i  input  PKTW+1  packet from the switch output port; i[PKTW]=1 marks a packet present this cycle.
REQ-006 o  output  PKTW+1  packet to the downstream link; o[PKTW]=1 means o holds the FIFO head.
REQ-007 ordy  input  1  downstream ready; a transfer occurs in any cycle with o[PKTW]=1 and ordy=1.
REQ-008 full  output  1  occupancy equals DEPTH.
REQ-009 cnt  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-010 drop  output  8  count of packets discarded on overflow, saturating.

Function
REQ-011 Storage: circular FIFO of DEPTH payload entries, with write pointer, read pointer and occupancy register.
REQ-012 Push condition: i[PKTW]=1 and (cnt<DEPTH, or a pop occurs in the same cycle).
REQ-013 Pop condition: cnt>0 and ordy=1.
REQ-014 Output, combinational from state: o[PKTW]=(cnt!=0); o[PKTW-1:0]=head payload when cnt!=0, else all zeros.
REQ-015 Latency: no bypass; a packet pushed into an empty FIFO appears on o in the cycle after the push edge.
REQ-016 Ordering: packets leave in strict arrival order, without loss or duplication, for every accepted packet.
REQ-017 Occupancy update per edge: push only -> cnt+1; pop only -> cnt-1; push and pop together -> cnt unchanged, both pointers advance.
REQ-018 Full with simultaneous pop: an incoming packet is accepted, not dropped; full stays 1.
REQ-019 Full without pop: an incoming valid packet is discarded; drop increments by 1, saturating at 255.
REQ-020 Pointers wrap modulo DEPTH with no bubble and no lost entry at the wrap boundary.
REQ-021 Empty with ordy=1: no pop; the read pointer is unchanged.
REQ-022 ordy=0 holds the head stable; o does not change until a pop occurs.
REQ-023 i[PKTW]=0: payload bits are ignored; no state change from the input side.
REQ-024 full is combinational from the occupancy register: full=(cnt==DEPTH).

Reset
REQ-025 rst=0 asynchronously clears both pointers, the occupancy register and drop; o=0, cnt=0, full=0 while rst=0.
REQ-026 Reset mid-operation discards all stored packets; after rst rises, behaviour is as from power-up, with the first push landing at entry 0.
REQ-027 FIFO payload storage does not require reset.

Verification
REQ-028 Reset, then one packet i={1,8'hA5} with ordy=1 -> o=0 in the push cycle; o={1,8'hA5} in the next cycle; o=0 the cycle after; cnt sequence 0,1,0.
REQ-029 ordy=0, push 0x01..0x05 on consecutive cycles -> cnt=4, full=1, drop=1; then ordy=1 -> o shows 0x01,0x02,0x03,0x04 on consecutive cycles, with no 0x05.
REQ-030 FIFO full (cnt=4), ordy=1, and a valid packet 0x77 in the same cycle -> cnt stays 4, drop unchanged, and 0x77 exits fifth.
REQ-031 Stream 10 packets 0x10..0x19 with ordy=1 and back-to-back pushes -> output matches in order across two pointer wraps; cnt stays at 1 after the first cycle.
REQ-032 ordy=0 with 300 packets offered to a full FIFO -> drop reaches 255 and holds.
REQ-033 Three packets stored, then rst pulsed low between clock edges -> o=0, cnt=0 and drop=0 immediately; a push after reset release outputs only the new packet.
